// File: rtl/mam_ahb3_arbiter.sv
// Two-master AHB3 arbiter between a CPU and MAM in front of one memory port.
// Grants change only at transfer boundaries. A starving CPU gets priority.
module mam_ahb3_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic       ahb3_in_clk_i,
  input  logic       ahb3_in_rst_i,
  input  logic [1:0] cpu_htrans_i,
  input  logic       cpu_hmastlock_i,
  input  logic [1:0] mam_htrans_i,
  input  logic       mam_hmastlock_i,
  input  logic       mem_hready_i,
  output logic       grant_cpu_o,
  output logic       grant_mam_o,
  output logic       addr_sel_o,
  output logic       data_sel_o,
  output logic       cpu_hready_o,
  output logic       mam_hready_o,
  output logic       starve_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    OWN_MAM,
    OWN_CPU
  } state_t;

  state_t        state;
  state_t        state_nxt;
  state_t        arb;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          req_cpu;
  logic          req_mam;
  logic          bnd_cpu;
  logic          bnd_mam;

  assign req_cpu = (cpu_htrans_i == 2'b10) | cpu_hmastlock_i;
  assign req_mam = (mam_htrans_i == 2'b10) | mam_hmastlock_i;

  assign bnd_cpu = mem_hready_i & (cpu_htrans_i == 2'b00)
                 & ~cpu_hmastlock_i;
  assign bnd_mam = mem_hready_i & (mam_htrans_i == 2'b00)
                 & ~mam_hmastlock_i;

  // Registered starve_o decides ties, so saturation wins next arbitration.
  always_comb begin
    arb = IDLE;
    priority case (1'b1)
      req_mam && !starve_o: arb = OWN_MAM;
      req_cpu:              arb = OWN_CPU;
      req_mam:              arb = OWN_MAM;
      default:              arb = IDLE;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arb;
      OWN_MAM: if (bnd_mam) state_nxt = arb;
      OWN_CPU: if (bnd_cpu) state_nxt = arb;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state == OWN_CPU)
      cnt_nxt = '0;
    else if (state == OWN_MAM && req_cpu && cnt != LIM)
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge ahb3_in_clk_i) begin
    if (ahb3_in_rst_i) begin
      state       <= IDLE;
      grant_cpu_o <= 1'b0;
      grant_mam_o <= 1'b0;
      addr_sel_o  <= 1'b0;
      data_sel_o  <= 1'b0;
      cnt         <= '0;
      starve_o    <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_cpu_o <= (state_nxt == OWN_CPU);
      grant_mam_o <= (state_nxt == OWN_MAM);
      if (state_nxt != IDLE)
        addr_sel_o <= (state_nxt == OWN_CPU);
      // Data phase follows the address phase that just completed.
      if (mem_hready_i)
        data_sel_o <= addr_sel_o;
      cnt         <= cnt_nxt;
      starve_o    <= (cnt_nxt == LIM);
    end
  end

  assign cpu_hready_o = mem_hready_i & (grant_cpu_o | data_sel_o);
  assign mam_hready_o = mem_hready_i & (grant_mam_o | ~data_sel_o);

endmodule

// File: tb/tb_mam_ahb3_arbiter.sv
// Directed bench for mam_ahb3_arbiter with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs checked before next edge.
module tb_mam_ahb3_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] cpu_htrans;
  logic       cpu_lock;
  logic [1:0] mam_htrans;
  logic       mam_lock;
  logic       hready;
  logic       grant_cpu;
  logic       grant_mam;
  logic       addr_sel;
  logic       data_sel;
  logic       cpu_hready;
  logic       mam_hready;
  logic       starve;

  int n_tot = 0;
  int n_bad = 0;

  mam_ahb3_arbiter #(.STARVE_LIMIT(16)) dut (
    .ahb3_in_clk_i  (clk),
    .ahb3_in_rst_i  (rst),
    .cpu_htrans_i   (cpu_htrans),
    .cpu_hmastlock_i(cpu_lock),
    .mam_htrans_i   (mam_htrans),
    .mam_hmastlock_i(mam_lock),
    .mem_hready_i   (hready),
    .grant_cpu_o    (grant_cpu),
    .grant_mam_o    (grant_mam),
    .addr_sel_o     (addr_sel),
    .data_sel_o     (data_sel),
    .cpu_hready_o   (cpu_hready),
    .mam_hready_o   (mam_hready),
    .starve_o       (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ct, input logic cl,
                       input logic [1:0] mt, input logic ml,
                       input logic hr);
    cpu_htrans = ct;
    cpu_lock   = cl;
    mam_htrans = mt;
    mam_lock   = ml;
    hready     = hr;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gcpu", 32'(grant_cpu), 32'd0);
    chk("rst_gmam", 32'(grant_mam), 32'd0);
    chk("rst_asel", 32'(addr_sel), 32'd0);
    chk("rst_dsel", 32'(data_sel), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);

    // both request from IDLE: MAM wins, CPU stalled
    drive(2'b10, 1'b0, 2'b10, 1'b0, 1'b1);
    tick();
    chk("both_gmam", 32'(grant_mam), 32'd1);
    chk("both_gcpu", 32'(grant_cpu), 32'd0);
    chk("both_asel", 32'(addr_sel), 32'd0);
    chk("both_cpu_hrdy", 32'(cpu_hready), 32'd0);
    chk("both_mam_hrdy", 32'(mam_hready), 32'd1);

    // locked MAM for 40 cycles, CPU starving
    drive(2'b10, 1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("lock_gmam", 32'(grant_mam), 32'd1);
      chk("lock_starve", 32'(starve), (i >= 16) ? 32'd1 : 32'd0);
    end

    // MAM releases at boundary, CPU takes over
    drive(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("hand_gcpu", 32'(grant_cpu), 32'd1);
    chk("hand_gmam", 32'(grant_mam), 32'd0);
    chk("hand_asel", 32'(addr_sel), 32'd1);
    chk("hand_starve", 32'(starve), 32'd1);
    tick();
    chk("clr_starve", 32'(starve), 32'd0);
    chk("cpu_dsel", 32'(data_sel), 32'd1);

    // CPU data phase stalled, MAM waits with NONSEQ
    drive(2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_gcpu", 32'(grant_cpu), 32'd1);
      chk("stall_dsel", 32'(data_sel), 32'd1);
      chk("stall_cpu_hrdy", 32'(cpu_hready), 32'd0);
      chk("stall_mam_hrdy", 32'(mam_hready), 32'd0);
    end
    drive(2'b00, 1'b0, 2'b10, 1'b0, 1'b1);
    chk("done_cpu_hrdy", 32'(cpu_hready), 32'd1);
    chk("done_mam_hrdy", 32'(mam_hready), 32'd0);
    chk("done_gmam", 32'(grant_mam), 32'd0);
    tick();
    chk("mam_gmam", 32'(grant_mam), 32'd1);
    chk("mam_asel", 32'(addr_sel), 32'd0);
    chk("mam_dsel_hold", 32'(data_sel), 32'd1);
    chk("mam_hrdy", 32'(mam_hready), 32'd1);
    drive(2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("mam_dsel", 32'(data_sel), 32'd0);

    // reset while CPU owns with memory stalled
    drive(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("pre_rst_gcpu", 32'(grant_cpu), 32'd1);
    tick();
    chk("pre_rst_dsel", 32'(data_sel), 32'd1);
    drive(2'b10, 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_gcpu", 32'(grant_cpu), 32'd0);
    chk("mid_rst_gmam", 32'(grant_mam), 32'd0);
    chk("mid_rst_asel", 32'(addr_sel), 32'd0);
    chk("mid_rst_dsel", 32'(data_sel), 32'd0);
    chk("mid_rst_starve", 32'(starve), 32'd0);
    chk("mid_rst_mam_hrdy", 32'(mam_hready), 32'd0);
    rst = 1'b0;

    // CPU alone, then idle 10 cycles: addr_sel holds 1
    drive(2'b10, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("solo_gcpu", 32'(grant_cpu), 32'd1);
    drive(2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_gcpu", 32'(grant_cpu), 32'd0);
      chk("idle_gmam", 32'(grant_mam), 32'd0);
      chk("idle_asel", 32'(addr_sel), 32'd1);
    end

    // saturate, drop to IDLE, then starve flag gives CPU the tie
    drive(2'b10, 1'b0, 2'b10, 1'b0, 1'b1);
    tick();
    chk("sat_gmam", 32'(grant_mam), 32'd1);
    drive(2'b10, 1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) tick();
    chk("sat_starve", 32'(starve), 32'd1);
    drive(2'b00, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    chk("sat_idle_gmam", 32'(grant_mam), 32'd0);
    chk("sat_idle_starve", 32'(starve), 32'd1);
    drive(2'b10, 1'b0, 2'b10, 1'b0, 1'b1);
    tick();
    chk("tie_gcpu", 32'(grant_cpu), 32'd1);
    chk("tie_gmam", 32'(grant_mam), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mam_ahb3_arbiter.md
MAM_AHB3_ARBITER -- requirements
Module: mam_ahb3_arbiter

Interface
REQ-001 The block SHALL use one clock, ahb3_in_clk_i, and a synchronous, active-high reset, ahb3_in_rst_i.
REQ-002 Parameter STARVE_LIMIT, default 16, SHALL set the number of cycles a requesting CPU waits behind MAM before it gets forced priority (range 1..255).
REQ-003 Ports (name, direction, width, meaning):
- ahb3_in_clk_i, in, 1, clock.
- ahb3_in_rst_i, in, 1, synchronous active-high reset.
- cpu_htrans_i, in, 2, CPU HTRANS.
- cpu_hmastlock_i, in, 1, CPU HMASTLOCK.
- mam_htrans_i, in, 2, MAM HTRANS.
- mam_hmastlock_i, in, 1, MAM HMASTLOCK.
- mem_hready_i, in, 1, memory HREADY.
- grant_cpu_o, out, 1, CPU owns the address phase.
- grant_mam_o, out, 1, MAM owns the address phase.
- addr_sel_o, out, 1, address/control mux select (1=CPU, 0=MAM).
- data_sel_o, out, 1, wdata/rdata/resp mux select for the current data phase (1=CPU).
- cpu_hready_o, out, 1, HREADY returned to the CPU.
- mam_hready_o, out, 1, HREADY returned to MAM.
- starve_o, out, 1, starvation mask active.

Function
REQ-004 A master's request (req_x) SHALL be htrans==NONSEQ (2'b10) OR hmastlock==1.
REQ-005 The FSM SHALL have exactly three states: IDLE, OWN_MAM and OWN_CPU.
REQ-006 Arbitration SHALL pick MAM if req_mam and not starve_o; else CPU if req_cpu; else MAM if req_mam; else none.
REQ-007 In IDLE, the arbitration result SHALL register into OWN_MAM or OWN_CPU on the next edge; if there is no request, the FSM stays in IDLE.
REQ-008 In OWN_x, a boundary SHALL exist when mem_hready_i==1 AND owner htrans==IDLE (2'b00) AND owner hmastlock==0.
REQ-009 At a boundary, the next state SHALL be the arbitration result, or IDLE if there is no request, which allows direct owner-to-owner handover.
REQ-010 Without a boundary, the owner SHALL keep the grant regardless of the other master; a locked owner is never preempted.
REQ-011 grant_cpu_o SHALL be 1 exactly when state==OWN_CPU, and grant_mam_o SHALL be 1 exactly when state==OWN_MAM; the two are never both 1.
REQ-012 addr_sel_o SHALL equal grant_cpu_o in the OWN states and SHALL hold its last value in IDLE.
REQ-013 data_sel_o SHALL register addr_sel_o on each edge where mem_hready_i==1 and SHALL hold otherwise (AHB pipeline tracking).
REQ-014 cpu_hready_o SHALL be mem_hready_i AND (grant_cpu_o OR data_sel_o).
REQ-015 mam_hready_o SHALL be mem_hready_i AND (grant_mam_o OR NOT data_sel_o).
REQ-016 A non-owner SHALL see HREADY=0 and therefore hold its pending NONSEQ.
REQ-017 The starvation counter (width clog2(STARVE_LIMIT+1)) SHALL increment each cycle that state==OWN_MAM and req_cpu, saturating at STARVE_LIMIT.
REQ-018 The starvation counter SHALL clear in any cycle where state==OWN_CPU.
REQ-019 starve_o SHALL be 1 exactly when counter==STARVE_LIMIT.
REQ-020 When a boundary and counter saturation occur in the same cycle, the registered starve_o SHALL be used, so the CPU wins the next arbitration.
REQ-021 When both masters request in IDLE in the same cycle, REQ-006 priority SHALL apply.
REQ-022 The outputs SHALL contain no combinational path from htrans or hmastlock to the grant outputs.

Reset
REQ-023 Reset SHALL force: state=IDLE, grant_cpu_o=0, grant_mam_o=0, addr_sel_o=0, data_sel_o=0, counter=0, starve_o=0.
REQ-024 Reset asserted mid-transfer SHALL take effect on the next edge, with no completion of the pending transfer.
REQ-025 Reset SHALL have priority over all other updates.

Verification
REQ-026 Both masters drive NONSEQ in IDLE with mem_hready_i=1 -> the cycle after, grant_mam_o=1 and addr_sel_o=0; cpu_hready_o=0 while the CPU waits.
REQ-027 MAM holds hmastlock=1 for 40 cycles with req_cpu=1 and STARVE_LIMIT=16 -> grant stays with MAM for all 40 cycles and starve_o=1 from cycle 16.
REQ-028 MAM drives IDLE (unlocked) at a boundary after starve_o=1, with both masters requesting -> next state OWN_CPU and the counter clears to 0 one cycle later.
REQ-029 CPU single read, then MAM NONSEQ during the CPU data phase with mem_hready_i=0 for 3 cycles -> data_sel_o stays 1 until mem_hready_i=1, and CPU rdata completes before MAM's address is accepted.
REQ-030 Reset pulsed while in OWN_CPU with mem_hready_i=0 -> all outputs at their REQ-023 values on the next edge.
REQ-031 With no requests for 10 cycles -> the FSM stays in IDLE and addr_sel_o holds its last value.
